data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data SRAM interface (en/wen/addr/wdata/rdata).
- The CPU drives the request in EXE and samples rdata in MEM. This block therefore returns read data exactly one clock after the request.
- Holds a byte-writable word RAM plus a small memory-mapped config-register window: LED, numeric display, switch input and free-running timer.
- Sits in the SoC top, directly opposite the CPU's data port.

Parameters:
- RAM_AW, 12, word-address width of the RAM (2^RAM_AW 32-bit words).
- CONF_BASE_HI, 16'hBFAF, addr[31:16] value that selects the config window.
- SW_W, 8, switch input width.
- LED_W, 16, LED output width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_sram_en  in  1  request valid this cycle
- data_sram_wen  in  4  byte write enables; 0 = read, nonzero = write
- data_sram_addr  in  32  byte address; bits [1:0] ignored
- data_sram_wdata  in  32  write data, lane i = bits [8i+7:8i]
- data_sram_rdata  out  32  read data, valid the cycle after the request
- switch_in  in  SW_W  asynchronous board switches
- led_out  out  LED_W  LED register
- num_out  out  32  numeric-display register

Behaviour:
- Reset (asynchronous assert) drives these to 0:
  - data_sram_rdata, led_out, num_out, timer, both switch synchroniser stages.
  - RAM contents are not reset.
- Decode:
  - conf_hit = (addr[31:16] == CONF_BASE_HI).
  - Otherwise the access goes to the RAM at word index addr[RAM_AW+1:2]. Upper bits are ignored, so the RAM aliases (wraps) across the address space.
- Config offsets (addr[15:0]):
  - 16'hF000 LED: RW, bits above LED_W read 0.
  - 16'hF010 NUM: RW.
  - 16'hF020 SWITCH: RO, zero-extended, taken from the 2-flop synchronised copy.
  - 16'hE000 TIMER: RW.
  - Any other offset reads 32'h0; writes to it are dropped.
- Reads (en=1, wen=0) at edge N: rdata after edge N+1 holds the addressed word as it was before edge N.
- Writes (en=1, wen!=0):
  - Only the enabled byte lanes update, at edge N.
  - rdata after that edge is the OLD word (read-first), for both RAM and config registers.
  - Writes to SWITCH are ignored.
- en=0: rdata holds its previous value; no state changes except the timer and the switch synchroniser.
- Timer:
  - Increments by 1 every clock and wraps from 32'hFFFFFFFF to 0.
  - A write to TIMER takes priority over the increment. The next value is the byte-merged old value with wdata; counting resumes on the following edge.
  - A read of TIMER at edge N returns the pre-edge value.
- Back-to-back requests are accepted every cycle; no stall or ready signal. A write at N followed by a read at N+1 to the same address returns the new data.
- Reset mid-operation: any pending rdata is cleared to 0 and register state returns to reset values. The RAM keeps its contents.
- Partial-width writes to LED use only lanes within LED_W.

Decomposition:
- Shared package data_sram_pkg holds:
  - CONF_BASE_HI and the offset constants (OFF_LED, OFF_NUM, OFF_SWITCH, OFF_TIMER).
  - A byte-merge helper function merge(old, wdata, wen).
- Sub-module sram_bytewrite_ram: 2^RAM_AW x 32, one port, synchronous read-first, 4 lane enables, no reset. Reused later for an instruction-side model.
- Top level holds decode, config registers, timer, switch synchroniser and the registered output mux select. The select is latched alongside the request so the output mux picks RAM versus config in the response cycle.

Test Plan:
- Full write then read:
  - Stimulus: write wen=4'hF, addr 32'h0000_0010, data 32'hDEADBEEF; next cycle read the same address.
  - Required: rdata=32'hDEADBEEF one cycle after the read; rdata after the write cycle is the old word.
- Byte lanes:
  - Stimulus: write 32'h11223344 full word, then wen=4'b0101 with data 32'hAABBCCDD, then read.
  - Required: rdata=32'h11BB33DD.
- Aliasing and hold:
  - With RAM_AW=12, write addr 32'h0000_0004, then read addr 32'h0000_4004 → same word.
  - Then drop en for 3 cycles → rdata unchanged.
- Timer:
  - Stimulus: write TIMER (addr 32'hBFAF_E000) = 32'hFFFF_FFFE, then read on the next cycle.
  - Required: rdata=32'hFFFF_FFFE.
  - A read two cycles later returns 32'h0 (wrap).
- Config window:
  - Drive switch_in=8'hA5.
  - After 3 idle cycles, read addr 32'hBFAF_F020 → 32'h0000_00A5.
  - Write LED 32'h1234_5678 → led_out=16'h5678.
  - Read offset 16'hF040 → 0.
- Asynchronous reset:
  - Assert reset between clock edges while a read response is pending.
  - Required: rdata, led_out, num_out and the timer go to 0 immediately; earlier RAM data is still readable after reset is released.

Source files
------------

// File: rtl/data_sram_pkg.sv
// Shared constants and helpers for the CPU data-SRAM responder and its RAM.
// Holds the config-window base, the register offsets and the byte-lane merge.
package data_sram_pkg;

    localparam logic [15:0] CONF_BASE_HI = 16'hBFAF;

    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF010;
    localparam logic [15:0] OFF_SWITCH = 16'hF020;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_NUM,
        SEL_SWITCH,
        SEL_TIMER,
        SEL_NONE
    } sel_e;

    // Replaces each byte lane of old whose enable bit is set with the same lane of wdata.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  wen);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM port: request fields driven in EXE, rdata returned one clock later.
// Handshake: a request is taken on every edge where data_sram_en is 1; there is no ready.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/sram_bytewrite_ram.sv
// Single-port 2^AW x 32 word RAM with per-byte write enables.
// Synchronous read-first: on an enabled edge rdata takes the word as it was before any write.
module sram_bytewrite_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder opposite the CPU data port: word RAM plus a config window
// (LED, numeric display, synchronised switches, free-running timer), one-cycle read latency.
module data_sram_responder #(
    parameter int          RAM_AW       = 12,
    parameter logic [15:0] CONF_BASE_HI = data_sram_pkg::CONF_BASE_HI,
    parameter int          SW_W         = 8,
    parameter int          LED_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_responder_if.slave bus,
    input  logic [SW_W-1:0]      switch_in,
    output logic [LED_W-1:0]     led_out,
    output logic [31:0]          num_out
);
    import data_sram_pkg::*;

    logic        conf_hit;
    logic [15:0] off;
    sel_e        sel;
    logic        wr;
    logic [31:0] conf_rdata;
    logic        ram_en;
    logic [31:0] ram_q;

    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [31:0]     timer;
    logic [31:0]     conf_q;
    logic            resp_ram;

    assign conf_hit = (bus.data_sram_addr[31:16] == CONF_BASE_HI);
    assign off      = bus.data_sram_addr[15:0];
    assign wr       = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
    assign ram_en   = bus.data_sram_en && (sel == SEL_RAM);

    always_comb begin
        sel = SEL_NONE;
        if (!conf_hit) begin
            sel = SEL_RAM;
        end else begin
            case (off)
                OFF_LED:    sel = SEL_LED;
                OFF_NUM:    sel = SEL_NUM;
                OFF_SWITCH: sel = SEL_SWITCH;
                OFF_TIMER:  sel = SEL_TIMER;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    // Pre-edge register values, so config writes are naturally read-first.
    always_comb begin
        conf_rdata = 32'h0;
        case (sel)
            SEL_LED:    conf_rdata = 32'(led_out);
            SEL_NUM:    conf_rdata = num_out;
            SEL_SWITCH: conf_rdata = 32'(sw_s2);
            SEL_TIMER:  conf_rdata = timer;
            default:    conf_rdata = 32'h0;
        endcase
    end

    sram_bytewrite_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .wen   (bus.data_sram_wen),
        .addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .wdata (bus.data_sram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            timer    <= 32'h0;
            led_out  <= '0;
            num_out  <= 32'h0;
            conf_q   <= 32'h0;
            resp_ram <= 1'b0;
        end else begin
            sw_s1 <= switch_in;
            sw_s2 <= sw_s1;

            if (wr && sel == SEL_TIMER) timer <= merge(timer, bus.data_sram_wdata, bus.data_sram_wen);
            else                        timer <= timer + 32'd1;

            if (wr && sel == SEL_LED)
                led_out <= LED_W'(merge(32'(led_out), bus.data_sram_wdata, bus.data_sram_wen));
            if (wr && sel == SEL_NUM)
                num_out <= merge(num_out, bus.data_sram_wdata, bus.data_sram_wen);

            // The RAM output register holds on its own; the config side is captured here.
            if (bus.data_sram_en) begin
                resp_ram <= (sel == SEL_RAM);
                if (sel != SEL_RAM) conf_q <= conf_rdata;
            end
        end
    end

    // After reset resp_ram=0 and conf_q=0, so rdata reads 0 without resetting the RAM.
    assign bus.data_sram_rdata = resp_ram ? ram_q : conf_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_data_sram_responder;

    logic       clk;
    logic       reset;
    logic [7:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    int tests_run;
    int tests_failed;

    data_sram_responder_if bus ();

    data_sram_responder #(
        .RAM_AW       (12),
        .CONF_BASE_HI (16'hBFAF),
        .SW_W         (8),
        .LED_W        (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .switch_in (switch_in),
        .led_out   (led_out),
        .num_out   (num_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request cycle: drive, pass one rising edge, land 1ns after it.
    task automatic cycle(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        switch_in = 8'h00;
        bus.data_sram_en = 1'b0;
        bus.data_sram_wen = 4'h0;
        bus.data_sram_addr = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        tests_run++;
        if (led_out !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
        end
        tests_run++;
        if (num_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_num: got %h expected %h", num_out, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        // First edge after release: timer is still 0 before it.
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_timer: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
    endtask

    task automatic test_full_write_read;
        cycle(1'b1, 4'hF, 32'h0000_0010, 32'h0102_0304);
        cycle(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0102_0304) begin
            tests_failed++;
            $display("FAIL write_read_first: got %h expected %h", bus.data_sram_rdata, 32'h0102_0304);
        end
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL full_read: got %h expected %h", bus.data_sram_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_lanes;
        cycle(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        cycle(1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h1122_3344) begin
            tests_failed++;
            $display("FAIL lane_read_first: got %h expected %h", bus.data_sram_rdata, 32'h1122_3344);
        end
        cycle(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h11BB_33DD) begin
            tests_failed++;
            $display("FAIL byte_lanes: got %h expected %h", bus.data_sram_rdata, 32'h11BB_33DD);
        end
    endtask

    task automatic test_alias_hold;
        cycle(1'b1, 4'hF, 32'h0000_0004, 32'hCAFE_F00D);
        cycle(1'b1, 4'h0, 32'h0000_4004, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL alias_read: got %h expected %h", bus.data_sram_rdata, 32'hCAFE_F00D);
        end
        // en=0 with live-looking write fields must neither respond nor write.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'hF, 32'h0000_0004, 32'h0000_0000);
            tests_run++;
            if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
                tests_failed++;
                $display("FAIL idle_hold_%0d: got %h expected %h", i, bus.data_sram_rdata, 32'hCAFE_F00D);
            end
        end
        cycle(1'b1, 4'h0, 32'h0000_0004, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL idle_no_write: got %h expected %h", bus.data_sram_rdata, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_timer;
        cycle(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL timer_written: got %h expected %h", bus.data_sram_rdata, 32'hFFFF_FFFE);
        end
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL timer_inc: got %h expected %h", bus.data_sram_rdata, 32'hFFFF_FFFF);
        end
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL timer_wrap: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        // Timer is 1 before this edge; lane-0 write merges 0xAA over it.
        cycle(1'b1, 4'b0001, 32'hBFAF_E000, 32'h1234_56AA);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h1) begin
            tests_failed++;
            $display("FAIL timer_write_old: got %h expected %h", bus.data_sram_rdata, 32'h1);
        end
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0000_00AA) begin
            tests_failed++;
            $display("FAIL timer_partial: got %h expected %h", bus.data_sram_rdata, 32'h0000_00AA);
        end
    endtask

    task automatic test_config;
        switch_in = 8'hA5;
        repeat (3) cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL switch_read: got %h expected %h", bus.data_sram_rdata, 32'h0000_00A5);
        end
        cycle(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
        tests_run++;
        if (led_out !== 16'h5678) begin
            tests_failed++;
            $display("FAIL led_write: got %h expected %h", led_out, 16'h5678);
        end
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL led_read_first: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        cycle(1'b1, 4'b1100, 32'hBFAF_F000, 32'hFFFF_FFFF);
        cycle(1'b1, 4'b0010, 32'hBFAF_F000, 32'h0000_AB00);
        tests_run++;
        if (led_out !== 16'hAB78) begin
            tests_failed++;
            $display("FAIL led_lanes: got %h expected %h", led_out, 16'hAB78);
        end
        cycle(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0000_AB78) begin
            tests_failed++;
            $display("FAIL led_read: got %h expected %h", bus.data_sram_rdata, 32'h0000_AB78);
        end
        cycle(1'b1, 4'hF, 32'hBFAF_F010, 32'h8765_4321);
        tests_run++;
        if (num_out !== 32'h8765_4321) begin
            tests_failed++;
            $display("FAIL num_write: got %h expected %h", num_out, 32'h8765_4321);
        end
        cycle(1'b1, 4'hF, 32'hBFAF_F040, 32'h5555_5555);
        cycle(1'b1, 4'h0, 32'hBFAF_F040, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        cycle(1'b1, 4'hF, 32'hBFAF_F020, 32'h0000_0000);
        cycle(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL switch_ro: got %h expected %h", bus.data_sram_rdata, 32'h0000_00A5);
        end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 4'hF, 32'h0000_0100, 32'h0BAD_F00D);
        cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0BAD_F00D) begin
            tests_failed++;
            $display("FAIL b2b_ram: got %h expected %h", bus.data_sram_rdata, 32'h0BAD_F00D);
        end
        cycle(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h8765_4321) begin
            tests_failed++;
            $display("FAIL b2b_num: got %h expected %h", bus.data_sram_rdata, 32'h8765_4321);
        end
        cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL b2b_back_ram: got %h expected %h", bus.data_sram_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b1, 4'hF, 32'h0000_0030, 32'h5A5A_1234);
        cycle(1'b1, 4'h0, 32'h0000_0030, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h5A5A_1234) begin
            tests_failed++;
            $display("FAIL pre_reset_read: got %h expected %h", bus.data_sram_rdata, 32'h5A5A_1234);
        end
        bus.data_sram_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        tests_run++;
        if (led_out !== 16'h0) begin
            tests_failed++;
            $display("FAIL async_led: got %h expected %h", led_out, 16'h0);
        end
        tests_run++;
        if (num_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_num: got %h expected %h", num_out, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_timer: got %h expected %h", bus.data_sram_rdata, 32'h0);
        end
        cycle(1'b1, 4'h0, 32'h0000_0030, 32'h0);
        tests_run++;
        if (bus.data_sram_rdata !== 32'h5A5A_1234) begin
            tests_failed++;
            $display("FAIL ram_kept: got %h expected %h", bus.data_sram_rdata, 32'h5A5A_1234);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_full_write_read();
        test_byte_lanes();
        test_alias_hold();
        test_timer();
        test_config();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
